// File: rtl/mux_sel_cfg_chain.sv
// Configuration-memory segment that shifts a select frame in serially and commits it to shadow selects.
// Optional macro CFG_READBACK_EN adds loading of the committed frame back into the chain.
module mux_sel_cfg_chain #(
    parameter  int NUM_MUX = 4,
    parameter  int SEL_W   = 4,
    localparam int L       = NUM_MUX * SEL_W,
    localparam int CW      = $clog2(L + 2)
) (
    input  logic         prog_clk,
    input  logic         pReset,
    input  logic         ccff_head,
    input  logic         shift_en,
    input  logic         commit,
    input  logic         readback,
    output logic         ccff_tail,
    output logic [0:L-1] sram,
    output logic [0:L-1] sram_inv,
    output logic         cfg_valid,
    output logic         cfg_err
);

    typedef enum logic [1:0] {
        IDLE,
        LOADING,
        FULL,
        OVER
    } state_t;

    localparam logic [CW-1:0] CNT_FULL = CW'(L);
    localparam logic [CW-1:0] CNT_OVER = CW'(L + 1);

    logic [0:L-1]  sr_q, sr_d;
    logic [0:L-1]  sram_q, sram_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          valid_q, valid_d;
    logic          err_q, err_d;
    state_t        state_q, state_d;
    logic          acceptCommit;

    always_ff @(posedge prog_clk) begin
        if (pReset) begin
            sr_q    <= '0;
            sram_q  <= '0;
            cnt_q   <= '0;
            valid_q <= 1'b0;
            err_q   <= 1'b0;
            state_q <= IDLE;
        end else begin
            sr_q    <= sr_d;
            sram_q  <= sram_d;
            cnt_q   <= cnt_d;
            valid_q <= valid_d;
            err_q   <= err_d;
            state_q <= state_d;
        end
    end

    // A commit only lands when a whole frame sits in the chain and nothing is moving.
    always_comb begin
        sr_d         = sr_q;
        sram_d       = sram_q;
        cnt_d        = cnt_q;
        valid_d      = valid_q;
        err_d        = err_q;
        acceptCommit = commit && !shift_en && (state_q == FULL);

        if (shift_en) begin
            sr_d  = {sr_q[1:L-1], ccff_head};
            cnt_d = (cnt_q == CNT_OVER) ? CNT_OVER : cnt_q + CW'(1);
        end

        if (commit) begin
            if (acceptCommit) begin
                sram_d  = sr_q;
                valid_d = 1'b1;
                err_d   = 1'b0;
                cnt_d   = '0;
            end else begin
                err_d = 1'b1;
            end
        end

`ifdef CFG_READBACK_EN
        if (readback && !shift_en && !commit) begin
            sr_d  = sram_q;
            cnt_d = CNT_FULL;
        end
`endif
    end

    // Occupancy state tracks the counter value it will hold after this edge.
    always_comb begin
        state_d = state_q;
        if (cnt_d == '0) begin
            state_d = IDLE;
        end else if (cnt_d < CNT_FULL) begin
            state_d = LOADING;
        end else if (cnt_d == CNT_FULL) begin
            state_d = FULL;
        end else begin
            state_d = OVER;
        end
    end

`ifndef CFG_READBACK_EN
    logic unused_readback;
    assign unused_readback = readback;
`endif

    assign ccff_tail = sr_q[0];
    assign sram      = sram_q;
    assign sram_inv  = ~sram_q;
    assign cfg_valid = valid_q;
    assign cfg_err   = err_q;

endmodule

// File: tb/tb_mux_sel_cfg_chain.sv
// Directed self-checking bench for mux_sel_cfg_chain (4 muxes x 4 select bits).
module tb_mux_sel_cfg_chain;

    localparam int L = 16;

    logic         prog_clk = 1'b0;
    logic         pReset = 1'b0;
    logic         ccff_head = 1'b0;
    logic         shift_en = 1'b0;
    logic         commit = 1'b0;
    logic         readback = 1'b0;
    logic         ccff_tail;
    logic [0:L-1] sram;
    logic [0:L-1] sram_inv;
    logic         cfg_valid;
    logic         cfg_err;

    int checks = 0;
    int errors = 0;

    mux_sel_cfg_chain #(.NUM_MUX(4), .SEL_W(4)) dut (
        .prog_clk (prog_clk),
        .pReset   (pReset),
        .ccff_head(ccff_head),
        .shift_en (shift_en),
        .commit   (commit),
        .readback (readback),
        .ccff_tail(ccff_tail),
        .sram     (sram),
        .sram_inv (sram_inv),
        .cfg_valid(cfg_valid),
        .cfg_err  (cfg_err)
    );

    always #5 prog_clk = ~prog_clk;

    // Inputs change and outputs are sampled 1 time unit after the rising edge.
    task automatic tick();
        @(posedge prog_clk);
        #1;
    endtask

    // Bit i of the returned word is sram[i], so mux k select = word[4k+3:4k].
    function automatic logic [15:0] packBits(input logic [0:L-1] v);
        logic [15:0] r;
        for (int i = 0; i < L; i++) r[i] = v[i];
        return r;
    endfunction

    task automatic checkOutput(input string tag, input logic [15:0] observed, input logic [15:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            errors++;
            $error("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input logic [15:0] value, input int nbits);
        for (int i = 0; i < nbits; i++) begin
            ccff_head = value[i];
            shift_en  = 1'b1;
            tick();
        end
        shift_en  = 1'b0;
        ccff_head = 1'b0;
    endtask

    task automatic pulseCommit();
        commit = 1'b1;
        tick();
        commit = 1'b0;
    endtask

    task automatic pulseReset(input int cycles);
        pReset = 1'b1;
        for (int i = 0; i < cycles; i++) tick();
        pReset = 1'b0;
    endtask

    logic [15:0] captured;
    logic [15:0] expectedStream;

    initial begin
        #1;
        // Reset state
        pulseReset(2);
        checkOutput("reset_sram", packBits(sram), 16'h0000);
        checkOutput("reset_sram_inv", packBits(sram_inv), 16'hFFFF);
        checkOutput("reset_valid", 16'(cfg_valid), 16'h0);
        checkOutput("reset_err", 16'(cfg_err), 16'h0);
        checkOutput("reset_tail", 16'(ccff_tail), 16'h0);

        // Full load and commit
        applyStimulus(16'hA5C3, 16);
        checkOutput("load_tail_bit0", 16'(ccff_tail), 16'h1);
        checkOutput("load_sram_stable", packBits(sram), 16'h0000);
        pulseCommit();
        checkOutput("commit_sram", packBits(sram), 16'hA5C3);
        checkOutput("commit_sram_inv", packBits(sram_inv), 16'h5A3C);
        checkOutput("commit_valid", 16'(cfg_valid), 16'h1);
        checkOutput("commit_err", 16'(cfg_err), 16'h0);
        captured = packBits(sram);
        checkOutput("mux0_sel", 16'(captured[3:0]), 16'h3);
        checkOutput("mux3_sel", 16'(captured[15:12]), 16'hA);

        // Short frame rejected, then completed and accepted
        applyStimulus(16'h3C96, 15);
        pulseCommit();
        checkOutput("short_err", 16'(cfg_err), 16'h1);
        checkOutput("short_sram_kept", packBits(sram), 16'hA5C3);
        applyStimulus(16'h3C96 >> 15, 1);
        pulseCommit();
        checkOutput("complete_err_clear", 16'(cfg_err), 16'h0);
        checkOutput("complete_sram", packBits(sram), 16'h3C96);

        // Overflow: 17 shifts then commit
        applyStimulus(16'hFFFF, 16);
        applyStimulus(16'h0001, 1);
        pulseCommit();
        checkOutput("overflow_err", 16'(cfg_err), 16'h1);
        checkOutput("overflow_sram_kept", packBits(sram), 16'h3C96);
        checkOutput("overflow_valid_kept", 16'(cfg_valid), 16'h1);

        // Commit colliding with a shift
        pulseReset(1);
        applyStimulus(16'h5A5A, 16);
        checkOutput("collide_tail_pre", 16'(ccff_tail), 16'h0);
        commit    = 1'b1;
        shift_en  = 1'b1;
        ccff_head = 1'b1;
        tick();
        commit    = 1'b0;
        shift_en  = 1'b0;
        ccff_head = 1'b0;
        checkOutput("collide_err", 16'(cfg_err), 16'h1);
        checkOutput("collide_sram", packBits(sram), 16'h0000);
        checkOutput("collide_valid", 16'(cfg_valid), 16'h0);
        checkOutput("collide_shifted_tail", 16'(ccff_tail), 16'h1);

        // Reset mid-load discards the partial frame
        pulseReset(1);
        applyStimulus(16'h00FF, 8);
        checkOutput("midload_tail_pre", 16'(ccff_tail), 16'h0);
        pulseReset(1);
        checkOutput("midload_err", 16'(cfg_err), 16'h0);
        applyStimulus(16'h1234, 16);
        pulseCommit();
        checkOutput("midload_sram", packBits(sram), 16'h1234);
        checkOutput("midload_valid", 16'(cfg_valid), 16'h1);

        // Readback streams the committed frame; otherwise the chain contents come out
        applyStimulus(16'hBEEF, 16);
        pulseCommit();
        checkOutput("rb_commit_sram", packBits(sram), 16'hBEEF);
        applyStimulus(16'h1357, 16);
        readback = 1'b1;
        tick();
        readback = 1'b0;
`ifdef CFG_READBACK_EN
        expectedStream = 16'hBEEF;
`else
        expectedStream = 16'h1357;
`endif
        for (int i = 0; i < L; i++) begin
            captured[i] = ccff_tail;
            applyStimulus(16'h0000, 1);
        end
        checkOutput("rb_stream", captured, expectedStream);
        checkOutput("rb_sram_kept", packBits(sram), 16'hBEEF);

        // Commit held for two cycles: first accepted, second rejected
        pulseReset(1);
        applyStimulus(16'h00FF, 16);
        commit = 1'b1;
        tick();
        checkOutput("hold1_sram", packBits(sram), 16'h00FF);
        checkOutput("hold1_err", 16'(cfg_err), 16'h0);
        tick();
        commit = 1'b0;
        checkOutput("hold2_err", 16'(cfg_err), 16'h1);
        checkOutput("hold2_sram", packBits(sram), 16'h00FF);
        checkOutput("hold2_valid", 16'(cfg_valid), 16'h1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
